// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared opcode, FSM state and flag-index definitions for the
//               4-bit ALU sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHR = 3'd2,
        OP_SHL = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_RSV = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } ctrl_state_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Loadable down-counter; done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Valid/ready sequencer for the combinational 4-bit ALU: holds
//               operands for SETTLE_CYC cycles, captures result and flags.
//               Optional macro ALU_ACC_CHAIN_EN adds cmd_chain + accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [2:0]       cmd_op,
`ifdef ALU_ACC_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_res,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_res,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] c_settle_ld = 4'(SETTLE_CYC - 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic             r_cmd_ready;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_rsp_valid;
    logic [W-1:0]     r_rsp_res;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_op_count;
    logic             w_accept;
    logic             w_legal;
    logic             w_timer_done;
    logic [W-1:0]     w_a_src;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_legal  = (cmd_op != OP_RSV);

    settle_timer #(
        .TW       (4)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept && w_legal),
        .load_val (c_settle_ld),
        .en       (r_state == ST_SETTLE),
        .done     (w_timer_done)
    );

`ifdef ALU_ACC_CHAIN_EN
    // Accumulator follows successful captures only; error responses leave it alone.
    logic [W-1:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_acc <= alu_res;
        end
    end

    assign w_a_src = cmd_chain ? r_acc : cmd_a;
`else
    assign w_a_src = cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_legal ? ST_SETTLE : ST_RESP;
                end
            end
            ST_SETTLE: begin
                if (w_timer_done) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; cmd_ready is precomputed from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_cmd_ready <= (w_next_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_alu_a  <= w_a_src;
                            r_alu_b  <= cmd_b;
                            r_alu_op <= cmd_op;
                        end else begin
                            r_rsp_res   <= '0;
                            r_rsp_flags <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_res   <= alu_res;
                    r_rsp_flags <= alu_flags;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_op_count  <= r_op_count + CNT_W'(1);
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire
